// File: rtl/ysyx_23060332_trap_ctrl_pkg.sv
// Shared types and constants for the trap controller: CSR addresses, mstatus bit
// positions, FSM state encoding and the CSR value transforms used by the sequencer.
package ysyx_23060332_trap_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 8;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Clears the two low bits of a PC-class value.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_T_EPC    = 3'd1,
    S_T_CAUSE  = 3'd2,
    S_T_STATUS = 3'd3,
    S_M_STATUS = 3'd4,
    S_REDIR    = 3'd5
  } state_e;

  function automatic logic [XLEN-1:0] mcause_word(input logic [CAUSE_W-1:0] c);
    return {c[CAUSE_W-1], {(XLEN-CAUSE_W){1'b0}}, c[CAUSE_W-2:0]};
  endfunction

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060332_trap_ctrl_if.sv
// Bundle of trap/mret handshakes, EXU CSR write request, CSR file view and redirect.
// slave = trap controller side, master = surrounding core side.
interface ysyx_23060332_trap_ctrl_if;
  import ysyx_23060332_trap_ctrl_pkg::*;

  logic               trap_req;
  logic [CAUSE_W-1:0] trap_cause;
  logic [XLEN-1:0]    trap_pc;
  logic               mret_req;
  logic               trap_ack;
  logic               mret_ack;
  logic               exu_csr_wen;
  logic [11:0]        exu_csr_waddr;
  logic [XLEN-1:0]    exu_csr_wdata;
  logic               exu_stall;
  logic [XLEN-1:0]    mstatus_i;
  logic [XLEN-1:0]    mtvec_i;
  logic [XLEN-1:0]    mepc_i;
  logic               csr_wen;
  logic [11:0]        csr_waddr;
  logic [XLEN-1:0]    csr_wdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               busy;

  modport slave (
    input  trap_req, trap_cause, trap_pc, mret_req,
           exu_csr_wen, exu_csr_waddr, exu_csr_wdata,
           mstatus_i, mtvec_i, mepc_i,
    output trap_ack, mret_ack, exu_stall, csr_wen, csr_waddr, csr_wdata,
           redirect_valid, redirect_pc, busy
  );

  modport master (
    output trap_req, trap_cause, trap_pc, mret_req,
           exu_csr_wen, exu_csr_waddr, exu_csr_wdata,
           mstatus_i, mtvec_i, mepc_i,
    input  trap_ack, mret_ack, exu_stall, csr_wen, csr_waddr, csr_wdata,
           redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/ysyx_23060332_trap_ctrl_target.sv
// Redirect target: mepc for mret, mtvec base (or vectored slot) for traps.
// Vectored interrupt slots are enabled by defining YSYX_23060332_TRAP_VECTORED_EN.
module ysyx_23060332_trap_target
  import ysyx_23060332_trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc,
  input  logic [CAUSE_W-1:0] cause,
  input  logic               is_mret,
  output logic [XLEN-1:0]    target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_target;

  assign base = mtvec & ALIGN_MASK;

`ifdef YSYX_23060332_TRAP_VECTORED_EN
  logic vectored;
  assign vectored    = (mtvec[1:0] == 2'b01) && cause[CAUSE_W-1];
  assign trap_target = vectored
                     ? base + {{(XLEN-CAUSE_W-1){1'b0}}, cause[CAUSE_W-2:0], 2'b00}
                     : base;
`else
  // Direct mode only: cause does not influence the target.
  logic unused_cause;
  assign unused_cause = ^cause;
  assign trap_target  = base;
`endif

  assign target = is_mret ? (mepc & ALIGN_MASK) : trap_target;

endmodule

// File: rtl/ysyx_23060332_trap_ctrl.sv
// Trap entry / mret sequencer owning the single CSR write port, arbitrated against EXU.
// Optional vectored trap targets: define YSYX_23060332_TRAP_VECTORED_EN.
module ysyx_23060332_trap_ctrl
  import ysyx_23060332_trap_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  ysyx_23060332_trap_ctrl_if.slave bus
);

  state_e             state, state_nxt;
  logic [XLEN-1:0]    pc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               is_mret_q;
  logic               trap_ack, mret_ack;
  logic [XLEN-1:0]    target;

  ysyx_23060332_trap_target u_target (
    .mtvec   (bus.mtvec_i),
    .mepc    (bus.mepc_i),
    .cause   (cause_q),
    .is_mret (is_mret_q),
    .target  (target)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (trap_ack) begin
        pc_q      <= bus.trap_pc;
        cause_q   <= bus.trap_cause;
        is_mret_q <= 1'b0;
      end else if (mret_ack) begin
        is_mret_q <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt          = state;
    trap_ack           = 1'b0;
    mret_ack           = 1'b0;
    bus.exu_stall      = 1'b0;
    bus.csr_wen        = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset masks the port so a write in flight never lands.
    if (!rst) begin
      bus.exu_stall = bus.exu_csr_wen &&
                      (state != S_IDLE || bus.trap_req || bus.mret_req);
      unique case (state)
        S_IDLE: begin
          if (bus.trap_req) begin
            trap_ack  = 1'b1;
            state_nxt = S_T_EPC;
          end else if (bus.mret_req) begin
            mret_ack  = 1'b1;
            state_nxt = S_M_STATUS;
          end else begin
            bus.csr_wen   = bus.exu_csr_wen;
            bus.csr_waddr = bus.exu_csr_waddr;
            bus.csr_wdata = bus.exu_csr_wdata;
          end
        end
        S_T_EPC: begin
          bus.csr_wen   = 1'b1;
          bus.csr_waddr = CSR_MEPC;
          bus.csr_wdata = pc_q & ALIGN_MASK;
          state_nxt     = S_T_CAUSE;
        end
        S_T_CAUSE: begin
          bus.csr_wen   = 1'b1;
          bus.csr_waddr = CSR_MCAUSE;
          bus.csr_wdata = mcause_word(cause_q);
          state_nxt     = S_T_STATUS;
        end
        S_T_STATUS: begin
          bus.csr_wen   = 1'b1;
          bus.csr_waddr = CSR_MSTATUS;
          bus.csr_wdata = trap_mstatus(bus.mstatus_i);
          state_nxt     = S_REDIR;
        end
        S_M_STATUS: begin
          bus.csr_wen   = 1'b1;
          bus.csr_waddr = CSR_MSTATUS;
          bus.csr_wdata = mret_mstatus(bus.mstatus_i);
          state_nxt     = S_REDIR;
        end
        S_REDIR: begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = target;
          state_nxt          = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.trap_ack = trap_ack;
  assign bus.mret_ack = mret_ack;
  assign bus.busy     = !rst && (state != S_IDLE);

endmodule

// File: tb/tb_ysyx_23060332_trap_ctrl.sv
// Self-checking bench for ysyx_23060332_trap_ctrl: directed spec cases plus randomized
// trap/mret/EXU traffic compared cycle by cycle against an arithmetic reference model.
module tb_ysyx_23060332_trap_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ysyx_23060332_trap_ctrl_if bus ();

  ysyx_23060332_trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic        stall;
    logic        tack;
    logic        mack;
  } obs_t;

  // ---------------- reference model (plain arithmetic on architectural rules)
  function automatic logic [31:0] m_mepc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] m_mcause(input logic [7:0] c);
    return (32'(c) & 32'h7F) | (32'(c >> 7) << 31);
  endfunction

  function automatic logic [31:0] m_trap_mstatus(input logic [31:0] s);
    logic [31:0] mie;
    mie = (s >> 3) & 32'd1;
    return (s & ~32'h0000_0088) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] m_mret_mstatus(input logic [31:0] s);
    logic [31:0] mpie;
    mpie = (s >> 7) & 32'd1;
    return (s & ~32'h0000_0008) | (mpie << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] mtvec, input logic [7:0] c);
    logic [31:0] t;
    t = mtvec & 32'hFFFF_FFFC;
`ifdef YSYX_23060332_TRAP_VECTORED_EN
    if ((mtvec % 4) == 1 && c >= 8'd128) t = t + 32'(c - 8'd128) * 32'd4;
`else
    if (c == 8'hxx) t = t;
`endif
    return t;
  endfunction

  // ---------------- observation
  function automatic obs_t sample();
    obs_t o;
    o.wen   = bus.csr_wen;
    o.waddr = bus.csr_waddr;
    o.wdata = bus.csr_wdata;
    o.rv    = bus.redirect_valid;
    o.rpc   = bus.redirect_pc;
    o.busy  = bus.busy;
    o.stall = bus.exu_stall;
    o.tack  = bus.trap_ack;
    o.mack  = bus.mret_ack;
    return o;
  endfunction

  // Address/data are don't-care when the port is not writing outside plain IDLE,
  // and the redirect target is don't-care without its strobe.
  function automatic obs_t observe(input obs_t e);
    obs_t o;
    o = sample();
    if (!e.wen && (e.busy || e.tack || e.mack)) begin
      o.waddr = '0;
      o.wdata = '0;
    end
    if (!e.rv) o.rpc = '0;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one trap or mret from IDLE and checks every cycle until REDIR completes.
  task automatic run_seq(input string name, input bit is_trap,
                         input logic [7:0] cause, input logic [31:0] pc,
                         input logic [31:0] mtvec, input logic [31:0] mepc,
                         input logic [31:0] mstatus, input bit exu_wen,
                         input logic [11:0] exu_addr, input logic [31:0] exu_data,
                         input bit also_mret, input bit hold_trap);
    obs_t exp_q[$];
    obs_t e;
    obs_t o;
    bus.trap_req      = is_trap;
    bus.mret_req      = !is_trap || also_mret;
    bus.trap_cause    = cause;
    bus.trap_pc       = pc;
    bus.mtvec_i       = mtvec;
    bus.mepc_i        = mepc;
    bus.mstatus_i     = mstatus;
    bus.exu_csr_wen   = exu_wen;
    bus.exu_csr_waddr = exu_addr;
    bus.exu_csr_wdata = exu_data;

    e = '0; e.tack = is_trap; e.mack = !is_trap; e.stall = exu_wen;
    exp_q.push_back(e);
    if (is_trap) begin
      e = '0; e.busy = 1; e.stall = exu_wen; e.wen = 1;
      e.waddr = 12'h341; e.wdata = m_mepc(pc);            exp_q.push_back(e);
      e.waddr = 12'h342; e.wdata = m_mcause(cause);       exp_q.push_back(e);
      e.waddr = 12'h300; e.wdata = m_trap_mstatus(mstatus); exp_q.push_back(e);
      e = '0; e.busy = 1; e.stall = exu_wen; e.rv = 1; e.rpc = m_target(mtvec, cause);
      exp_q.push_back(e);
    end else begin
      e = '0; e.busy = 1; e.stall = exu_wen; e.wen = 1;
      e.waddr = 12'h300; e.wdata = m_mret_mstatus(mstatus); exp_q.push_back(e);
      e = '0; e.busy = 1; e.stall = exu_wen; e.rv = 1; e.rpc = mepc & 32'hFFFF_FFFC;
      exp_q.push_back(e);
    end

    foreach (exp_q[k]) begin
      @(negedge clk);
      o = observe(exp_q[k]);
      n_checks++;
      if (o !== exp_q[k]) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, o, exp_q[k]);
      end
      step();
      if (k == 0) begin
        bus.trap_req   = hold_trap;
        bus.mret_req   = is_trap && also_mret;
        bus.trap_pc    = $urandom;
        bus.trap_cause = 8'($urandom);
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    obs_t e;
    obs_t o;
    for (int i = 0; i < cycles; i++) begin
      bus.trap_req      = 1'b0;
      bus.mret_req      = 1'b0;
      bus.exu_csr_wen   = 1'($urandom);
      bus.exu_csr_waddr = 12'($urandom);
      bus.exu_csr_wdata = $urandom;
      e = '0;
      e.wen = bus.exu_csr_wen; e.waddr = bus.exu_csr_waddr; e.wdata = bus.exu_csr_wdata;
      @(negedge clk);
      o = observe(e);
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, o, e);
      end
      step();
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    obs_t o;
    rst               = 1'b1;
    bus.trap_req      = 1'b1;
    bus.mret_req      = 1'b1;
    bus.exu_csr_wen   = 1'b0;
    bus.exu_csr_waddr = 12'($urandom) | 12'h001;
    bus.exu_csr_wdata = $urandom | 32'h1;
    bus.mtvec_i       = 32'h8000_1000;
    bus.mepc_i        = 32'h8000_0014;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      o = sample();
      n_checks++;
      if (o !== '0) begin
        n_errors++;
        $display("FAIL reset cycle %0d: got %h expected all-zero", i, o);
      end
    end
    step();
    rst          = 1'b0;
    bus.trap_req = 1'b0;
    bus.mret_req = 1'b0;
  endtask

  task automatic test_idle_passthrough();
    check_idle("idle_passthrough", 6);
  endtask

  task automatic test_trap_basic();
    run_seq("trap_basic", 1'b1, 8'd11, 32'h8000_0010, 32'h8000_1000, 32'h1234_5678,
            32'h0000_1808, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_mret_basic();
    run_seq("mret_basic", 1'b0, 8'd0, 32'h0, 32'h8000_1000, 32'h8000_0014,
            32'h0000_1880, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_exu_stall();
    obs_t e;
    obs_t o;
    run_seq("exu_stall", 1'b1, 8'd2, 32'h8000_0100, 32'h8000_1000, 32'h0,
            32'h0000_0008, 1'b1, 12'h305, 32'h8000_2000, 1'b0, 1'b0);
    e = '0; e.wen = 1; e.waddr = 12'h305; e.wdata = 32'h8000_2000;
    @(negedge clk);
    o = observe(e);
    n_checks++;
    if (o !== e) begin
      n_errors++;
      $display("FAIL exu_stall_release: got %h expected %h", o, e);
    end
    step();
    bus.exu_csr_wen = 1'b0;
  endtask

  task automatic test_collision();
    run_seq("collision_trap", 1'b1, 8'd3, 32'h8000_0200, 32'h8000_1000, 32'h8000_0300,
            32'h0000_1888, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    run_seq("collision_mret", 1'b0, 8'd0, 32'h0, 32'h8000_1000, 32'h8000_0300,
            32'h0000_1880, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_first", 1'b1, 8'd5, 32'h8000_0400, 32'h8000_1100, 32'h0,
            32'h0000_0008, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
    run_seq("b2b_second", 1'b1, 8'd7, 32'h8000_0500, 32'h8000_1100, 32'h0,
            32'h0000_0080, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    obs_t e;
    obs_t o;
    bus.trap_req    = 1'b1;
    bus.mret_req    = 1'b0;
    bus.trap_cause  = 8'd11;
    bus.trap_pc     = 32'h8000_0010;
    bus.mtvec_i     = 32'h8000_1000;
    bus.mstatus_i   = 32'h0000_1808;
    bus.exu_csr_wen = 1'b0;
    e = '0; e.tack = 1;
    @(negedge clk);
    o = observe(e);
    n_checks++;
    if (o !== e) begin
      n_errors++;
      $display("FAIL rst_mid_ack: got %h expected %h", o, e);
    end
    step();
    bus.trap_req = 1'b0;
    e = '0; e.busy = 1; e.wen = 1; e.waddr = 12'h341; e.wdata = 32'h8000_0010;
    @(negedge clk);
    o = observe(e);
    n_checks++;
    if (o !== e) begin
      n_errors++;
      $display("FAIL rst_mid_epc: got %h expected %h", o, e);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_cause: got %h expected all-zero", o);
    end
    step();
    rst = 1'b0;
    check_idle("rst_mid_after", 4);
  endtask

  task automatic test_vectored();
    run_seq("vectored", 1'b1, 8'h87, 32'h8000_0040, 32'h8000_1001, 32'h0,
            32'h0000_1808, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: run_seq("rand_trap", 1'b1, 8'($urandom), $urandom, $urandom, $urandom,
                   $urandom, 1'($urandom), 12'($urandom), $urandom, 1'b0, 1'b0);
        1: run_seq("rand_mret", 1'b0, 8'($urandom), $urandom, $urandom, $urandom,
                   $urandom, 1'($urandom), 12'($urandom), $urandom, 1'b0, 1'b0);
        default: check_idle("rand_idle", $urandom_range(1, 3));
      endcase
    end
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst               = 1'b1;
    bus.trap_req      = 1'b0;
    bus.trap_cause    = '0;
    bus.trap_pc       = '0;
    bus.mret_req      = 1'b0;
    bus.exu_csr_wen   = 1'b0;
    bus.exu_csr_waddr = '0;
    bus.exu_csr_wdata = '0;
    bus.mstatus_i     = '0;
    bus.mtvec_i       = '0;
    bus.mepc_i        = '0;

    test_reset();
    test_idle_passthrough();
    test_trap_basic();
    test_mret_basic();
    test_exu_stall();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_vectored();
    test_random();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
